// File: rtl/b_chan_pkg.sv
// Shared definitions for the b_chan_pipe lane combiner: mode encodings, lane slicing
// and pipeline depth limits.
package b_chan_pkg;

  typedef enum logic [1:0] {
    MODE_AND_XOR = 2'b00,
    MODE_OR_XNOR = 2'b01,
    MODE_PASS    = 2'b10,
    MODE_SWAP    = 2'b11
  } b_mode_e;

  localparam int unsigned MinDepth = 1;
  localparam int unsigned MaxDepth = 4;

  // Entries in the output skid buffer that terminates the pipeline.
  localparam int unsigned SkidEntries = 2;

  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

  function automatic bit depth_legal(input int unsigned depth);
    return (depth >= MinDepth) && (depth <= MaxDepth);
  endfunction

endpackage

// File: rtl/b_chan_stage.sv
// One elastic pipeline register: loads when empty or when its beat leaves in the same cycle.
module b_chan_stage
  import b_chan_pkg::*;
#(
  parameter int unsigned PayloadW = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [PayloadW-1:0] in_data_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [PayloadW-1:0] out_data_o
);

  logic                valid_q, valid_d;
  logic [PayloadW-1:0] data_q, data_d;
  logic                load;

  assign in_ready_o  = ~valid_q | out_ready_i;
  assign load        = in_valid_i & in_ready_o;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
    if (flush_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/b_chan_pipe.sv
// Multi-lane mask-gated combiner followed by an elastic pipeline whose last stage is a
// two-entry skid buffer, so in_ready never depends combinationally on out_ready.
module b_chan_pipe
  import b_chan_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*WIDTH-1:0]    in_a,
  input  logic [CHANNELS*WIDTH-1:0]    in_b,
  input  logic [CHANNELS*WIDTH-1:0]    in_mask,
  input  logic [1:0]                   in_mode,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*WIDTH-1:0]    out_x,
  output logic [CHANNELS*WIDTH-1:0]    out_y,
  output logic [CNT_W-1:0]             xfer_cnt,
  output logic                         cnt_sat
);

  localparam int unsigned BusW = CHANNELS * WIDTH;
  localparam int unsigned PayW = 2 * BusW;

  if (!depth_legal(DEPTH)) begin : g_depth_chk
    $error("b_chan_pipe: DEPTH must lie in 1..4");
  end

  // Combine at the input so the mode travels with its beat.
  logic [BusW-1:0] comb_x, comb_y;

  always_comb begin
    comb_x = '0;
    comb_y = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      unique case (b_mode_e'(in_mode))
        MODE_AND_XOR: begin
          comb_x[lane_lsb(k, WIDTH) +: WIDTH] = in_b[lane_lsb(k, WIDTH) +: WIDTH] &
                                                in_mask[lane_lsb(k, WIDTH) +: WIDTH];
          comb_y[lane_lsb(k, WIDTH) +: WIDTH] = in_a[lane_lsb(k, WIDTH) +: WIDTH] ^
                                                in_mask[lane_lsb(k, WIDTH) +: WIDTH];
        end
        MODE_OR_XNOR: begin
          comb_x[lane_lsb(k, WIDTH) +: WIDTH] = in_b[lane_lsb(k, WIDTH) +: WIDTH] |
                                                in_mask[lane_lsb(k, WIDTH) +: WIDTH];
          comb_y[lane_lsb(k, WIDTH) +: WIDTH] = ~(in_a[lane_lsb(k, WIDTH) +: WIDTH] ^
                                                  in_mask[lane_lsb(k, WIDTH) +: WIDTH]);
        end
        MODE_PASS: begin
          comb_x[lane_lsb(k, WIDTH) +: WIDTH] = in_a[lane_lsb(k, WIDTH) +: WIDTH];
          comb_y[lane_lsb(k, WIDTH) +: WIDTH] = in_b[lane_lsb(k, WIDTH) +: WIDTH];
        end
        MODE_SWAP: begin
          comb_x[lane_lsb(k, WIDTH) +: WIDTH] = in_b[lane_lsb(k, WIDTH) +: WIDTH];
          comb_y[lane_lsb(k, WIDTH) +: WIDTH] = in_a[lane_lsb(k, WIDTH) +: WIDTH];
        end
        default: ;
      endcase
    end
  end

  // Level i is the input side of stage i; level DEPTH-1 feeds the skid buffer.
  logic            lvl_valid [DEPTH];
  logic [PayW-1:0] lvl_data  [DEPTH];
  logic            skid_ready;

  assign lvl_valid[0] = in_valid;
  assign lvl_data[0]  = {comb_x, comb_y};

  for (genvar i = 0; i < DEPTH - 1; i++) begin : g_stage
    logic up_ready;
    logic dn_ready;

    if (i == DEPTH - 2) begin : g_tail
      assign dn_ready = skid_ready;
    end else begin : g_link
      assign dn_ready = g_stage[i + 1].up_ready;
    end

    b_chan_stage #(
      .PayloadW (PayW)
    ) u_stage (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (flush),
      .in_valid_i  (lvl_valid[i]),
      .in_ready_o  (up_ready),
      .in_data_i   (lvl_data[i]),
      .out_valid_o (lvl_valid[i + 1]),
      .out_ready_i (dn_ready),
      .out_data_o  (lvl_data[i + 1])
    );
  end

  if (DEPTH == 1) begin : g_no_stage
    assign in_ready = skid_ready;
  end else begin : g_head
    assign in_ready = g_stage[0].up_ready;
  end

  // Skid buffer: head drives the outputs directly and is never cleared on delivery,
  // so out_x/out_y hold their last value while empty.
  logic [PayW-1:0] head_q, head_d;
  logic [PayW-1:0] tail_q, tail_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            push, pop;

  assign skid_ready = (cnt_q != 2'(SkidEntries));
  assign push       = lvl_valid[DEPTH-1] & skid_ready;
  assign out_valid  = (cnt_q != 2'd0);
  assign pop        = out_valid & out_ready;
  assign out_x      = head_q[PayW-1 -: BusW];
  assign out_y      = head_q[BusW-1:0];

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          head_d = lvl_data[DEPTH-1];
        end else begin
          tail_d = lvl_data[DEPTH-1];
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        if (cnt_q == 2'd2) begin
          head_d = tail_q;
        end
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd2) begin
          head_d = tail_q;
          tail_d = lvl_data[DEPTH-1];
        end else begin
          head_d = lvl_data[DEPTH-1];
        end
      end
      default: ;
    endcase
    if (flush) begin
      cnt_d = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Delivery counter saturates instead of wrapping; the sticky flag marks the lost count.
  logic [CNT_W-1:0] xfer_q, xfer_d;
  logic             sat_q, sat_d;

  always_comb begin
    xfer_d = xfer_q;
    sat_d  = sat_q;
    if (pop) begin
      if (xfer_q == {CNT_W{1'b1}}) begin
        sat_d = 1'b1;
      end else begin
        xfer_d = xfer_q + CNT_W'(1);
      end
    end
    if (flush) begin
      xfer_d = '0;
      sat_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      xfer_q <= xfer_d;
      sat_q  <= sat_d;
    end
  end

  assign xfer_cnt = xfer_q;
  assign cnt_sat  = sat_q;

endmodule

// File: tb/tb_b_chan_pipe.sv
// Scoreboard bench for b_chan_pipe: stimulus pushes expected beats, a monitor pops on delivery.
module tb_b_chan_pipe;

  localparam int unsigned W     = 8;
  localparam int unsigned CH    = 4;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned BusW  = W * CH;
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [BusW-1:0] in_a = '0, in_b = '0, in_mask = '0;
  logic [1:0]      in_mode = 2'b00;
  logic            in_ready, out_valid, cnt_sat;
  logic [BusW-1:0] out_x, out_y;
  logic [CNT_W-1:0] xfer_cnt;

  int n_chk = 0;
  int n_fail = 0;
  logic [2*BusW-1:0] exp_q[$];
  logic [CNT_W-1:0]  exp_cnt = '0;
  logic              exp_sat = 1'b0;
  bit                gap_chk = 1'b0;

  // Directed vectors: a, b, mask, mode, expected x, expected y.
  logic [31:0] va [6] = '{32'hFFFFFFFF, 32'h00000000, 32'hDEADBEEF, 32'hDEADBEEF,
                          32'h80808080, 32'hA5A5A5A5};
  logic [31:0] vb [6] = '{32'h12345678, 32'h0000F000, 32'hCAFEF00D, 32'hCAFEF00D,
                          32'hFFFFFFFF, 32'h01020304};
  logic [31:0] vm [6] = '{32'h00FF00FF, 32'h0F0F0F0F, 32'hFFFFFFFF, 32'hFFFFFFFF,
                          32'h80000001, 32'h10203040};
  logic [1:0]  vmd [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
  logic [31:0] vx [6] = '{32'h00340078, 32'h0F0FFF0F, 32'hDEADBEEF, 32'hCAFEF00D,
                          32'h80000001, 32'h11223344};
  logic [31:0] vy [6] = '{32'hFF00FF00, 32'hF0F0F0F0, 32'hCAFEF00D, 32'hDEADBEEF,
                          32'h00808081, 32'h4A7A6A1A};

  b_chan_pipe #(
    .WIDTH    (W),
    .CHANNELS (CH),
    .DEPTH    (DEPTH),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mask   (in_mask),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .xfer_cnt  (xfer_cnt),
    .cnt_sat   (cnt_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] m,
                      input logic [1:0] mode, input logic [31:0] ex, input logic [31:0] ey);
    in_a = a;
    in_b = b;
    in_mask = m;
    in_mode = mode;
    in_valid = 1'b1;
    for (int t = 0; t < 40; t++) begin
      if (in_ready) begin
        exp_q.push_back({ex, ey});
        tick();
        in_valid = 1'b0;
        return;
      end
      tick();
    end
    n_chk++;
    n_fail++;
    $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 40 cycles");
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input int i);
    send(va[i], vb[i], vm[i], vmd[i], vx[i], vy[i]);
  endtask

  task automatic drain();
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) tick();
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: compares delivered beats, counter/flag model, output stability and streaming.
  logic            stall_prev = 1'b0;
  logic [BusW-1:0] hold_x, hold_y;
  logic [2*BusW-1:0] e;

  always @(negedge clk) begin
    if (rst_n) begin
      check("xfer_cnt", 64'(xfer_cnt), 64'(exp_cnt));
      check("cnt_sat", 64'(cnt_sat), 64'(exp_sat));
      if (gap_chk) check("out_valid_stream", 64'(out_valid), 64'(exp_q.size() != 0));
      if (stall_prev && out_valid) begin
        check("hold_x", 64'(out_x), 64'(hold_x));
        check("hold_y", 64'(out_y), 64'(hold_y));
      end
      stall_prev = out_valid && !out_ready;
      hold_x = out_x;
      hold_y = out_y;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_beat: got x=0x%0h y=0x%0h, expected no beat", out_x, out_y);
        end else begin
          e = exp_q.pop_front();
          check("out_x", 64'(out_x), 64'(e[2*BusW-1 -: BusW]));
          check("out_y", 64'(out_y), 64'(e[BusW-1:0]));
        end
        if (exp_cnt == CntMax) exp_sat = 1'b1;
        else exp_cnt = exp_cnt + 1'b1;
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. Reset then idle
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_xfer_cnt", 64'(xfer_cnt), 64'd0);
    check("rst_out_x", 64'(out_x), 64'd0);
    check("rst_out_y", 64'(out_y), 64'd0);

    // 2. Single beat, two-edge latency
    send(32'h12345678, 32'hFF00FF00, 32'h0F0F0F0F, 2'b00, 32'h0F000F00, 32'h1D3B5977);
    tick();
    @(negedge clk);
    check("lat_out_valid", 64'(out_valid), 64'd1);
    check("lat_out_x", 64'(out_x), 64'h0F000F00);
    tick();
    out_ready = 1'b1;
    drain();
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    check("single_xfer_cnt", 64'(xfer_cnt), 64'd1);
    check("single_out_valid", 64'(out_valid), 64'd0);
    check("single_x_held", 64'(out_x), 64'h0F000F00);

    // 3. Backpressure: three beats fill the pipe
    send_vec(0);
    send_vec(1);
    send_vec(2);
    @(negedge clk);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_out_x", 64'(out_x), 64'(vx[0]));
    tick();
    out_ready = 1'b1;
    gap_chk = 1'b1;
    send_vec(3);
    send_vec(4);
    send_vec(5);
    drain();
    tick();
    gap_chk = 1'b0;

    // 4. Mode mix back to back
    send(32'hAAAAAAAA, 32'h55555555, 32'h12345678, 2'b10, 32'hAAAAAAAA, 32'h55555555);
    send(32'hAAAAAAAA, 32'h55555555, 32'h12345678, 2'b11, 32'h55555555, 32'hAAAAAAAA);
    drain();
    tick();

    // 5. Flush with beats in flight
    out_ready = 1'b0;
    send_vec(0);
    send_vec(1);
    send_vec(2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.delete();
    exp_cnt = '0;
    exp_sat = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_xfer_cnt", 64'(xfer_cnt), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    tick();
    out_ready = 1'b1;
    send_vec(4);
    drain();
    tick();

    // 6. Counter saturation, then async reset mid-stream
    out_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_cnt = '0;
    exp_sat = 1'b0;
    out_ready = 1'b1;
    for (int k = 1; k <= 17; k++) send(32'(k), ~32'(k), 32'h0, 2'b10, 32'(k), ~32'(k));
    drain();
    tick();
    @(negedge clk);
    check("sat_xfer_cnt", 64'(xfer_cnt), 64'd15);
    check("sat_flag", 64'(cnt_sat), 64'd1);
    send_vec(3);
    send_vec(5);
    drain();
    tick();
    @(negedge clk);
    check("sat_sticky_cnt", 64'(xfer_cnt), 64'd15);
    check("sat_sticky_flag", 64'(cnt_sat), 64'd1);

    out_ready = 1'b0;
    send_vec(0);
    send_vec(1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    exp_q.delete();
    exp_cnt = '0;
    exp_sat = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_xfer_cnt", 64'(xfer_cnt), 64'd0);
    check("arst_cnt_sat", 64'(cnt_sat), 64'd0);
    check("arst_out_x", 64'(out_x), 64'd0);
    check("arst_out_y", 64'(out_y), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    send_vec(2);
    drain();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
